// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master mem_if arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int ADDR_W      = 32;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_t;

  typedef logic master_idx_t;

endpackage

// File: rtl/mem_if.sv
// Synchronous memory bus: request fields held until hit, done one cycle after hit.
// Latency: n/a (signal bundle only).
// Backpressure: requester holds its request stable until it sees hit.
interface mem_if
  import mem_arb_pkg::*;
#(
  parameter int LINE_BYTES = 4
) ();

  logic [ADDR_W-1:0]       addr;
  logic [LINE_BYTES*8-1:0] data_i;
  logic [LINE_BYTES-1:0]   data_en;
  logic                    read_en;
  logic                    write_en;
  logic                    hit;
  logic                    done;
  logic [LINE_BYTES*8-1:0] data_o;

  // Slave side of the bus: receives requests, answers with hit/done/data.
  modport bus (
    input  addr, data_i, data_en, read_en, write_en,
    output hit, done, data_o
  );

  // Master side of the bus: issues requests, consumes hit/done/data.
  modport driver (
    output addr, data_i, data_en, read_en, write_en,
    input  hit, done, data_o
  );

endinterface

// File: rtl/rr_pick.sv
// Two-way round-robin selector: grants the requester that did not win last time on a tie.
// Latency: purely combinational.
// Backpressure: none; valid simply reflects whether anyone is requesting.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  master_idx_t            last_grant,
  output logic                   valid,
  output master_idx_t            winner
);

  assign valid  = |req;
  // A lone requester wins outright; on a tie the pointer hands the grant to the other side.
  assign winner = (&req) ? master_idx_t'(~last_grant) : master_idx_t'(req[1]);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one mem_if memory port between two masters with round-robin grant held until hit.
// Latency: zero added cycles; request, hit and done pass through combinationally.
// Backpressure: the losing master sees hit=0 and keeps its request asserted until granted.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_BYTES = 4
) (
  input  logic   clk,
  input  logic   reset,
  mem_if.bus     m0,
  mem_if.bus     m1,
  mem_if.driver  mem
);

  arb_state_t  r_state;
  master_idx_t r_owner;
  master_idx_t r_last_grant;
  master_idx_t r_done_owner;
  logic        r_done_valid;

  logic [NUM_MASTERS-1:0]  w_req;
  logic                    w_pick_valid;
  master_idx_t             w_pick_winner;
  logic                    w_active;
  master_idx_t             w_sel;
  logic                    w_hit_ok;
  logic                    w_done_ok;
  logic [ADDR_W-1:0]       w_addr;
  logic [LINE_BYTES*8-1:0] w_data_i;
  logic [LINE_BYTES-1:0]   w_data_en;
  logic                    w_read_en;
  logic                    w_write_en;

  assign w_req = {m1.read_en | m1.write_en, m0.read_en | m0.write_en};

  rr_pick u_pick (
    .req        (w_req),
    .last_grant (r_last_grant),
    .valid      (w_pick_valid),
    .winner     (w_pick_winner)
  );

  // Decide who drives the memory this cycle: the held owner, or a fresh pick when idle.
  // An owner that drops its request (abort) or a reset cycle leaves the port idle.
  always_comb begin
    w_active = 1'b0;
    w_sel    = r_owner;
    if (!reset) begin
      if (r_state == OWN) begin
        w_sel    = r_owner;
        w_active = w_req[r_owner];
      end else begin
        w_sel    = w_pick_winner;
        w_active = w_pick_valid;
      end
    end
  end

  // Route the selected master's request fields to memory; all zero when nobody is served.
  always_comb begin
    w_addr     = '0;
    w_data_i   = '0;
    w_data_en  = '0;
    w_read_en  = 1'b0;
    w_write_en = 1'b0;
    if (w_active) begin
      if (w_sel == 1'b1) begin
        w_addr     = m1.addr;
        w_data_i   = m1.data_i;
        w_data_en  = m1.data_en;
        w_read_en  = m1.read_en;
        w_write_en = m1.write_en;
      end else begin
        w_addr     = m0.addr;
        w_data_i   = m0.data_i;
        w_data_en  = m0.data_en;
        w_read_en  = m0.read_en;
        w_write_en = m0.write_en;
      end
    end
  end

  assign mem.addr     = w_addr;
  assign mem.data_i   = w_data_i;
  assign mem.data_en  = w_data_en;
  assign mem.read_en  = w_read_en;
  assign mem.write_en = w_write_en;

  // hit only counts when it lands on a live request; done only when a hit preceded it.
  assign w_hit_ok  = w_active & mem.hit;
  assign w_done_ok = ~reset & r_done_valid & mem.done;

  assign m0.hit    = w_hit_ok & (w_sel == 1'b0);
  assign m1.hit    = w_hit_ok & (w_sel == 1'b1);
  assign m0.done   = w_done_ok & (r_done_owner == 1'b0);
  assign m1.done   = w_done_ok & (r_done_owner == 1'b1);
  assign m0.data_o = mem.data_o;
  assign m1.data_o = mem.data_o;

  // Grant FSM plus the round-robin pointer and the done-routing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_done_owner <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      r_done_valid <= w_hit_ok;
      if (w_hit_ok) begin
        r_done_owner <= w_sel;
      end
      case (r_state)
        ARB: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_winner;
            if (mem.hit) begin
              r_last_grant <= w_pick_winner;
            end else begin
              r_state <= OWN;
            end
          end
        end
        OWN: begin
          if (!w_active) begin
            r_state <= ARB;
          end else if (mem.hit) begin
            r_state      <= ARB;
            r_last_grant <= r_owner;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios then randomized traffic.
// Latency: outputs checked 1ns after inputs settle, before the next rising edge.
// Backpressure: modelled masters hold requests until the model predicts their hit.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_if #(.LINE_BYTES(4)) bus0 ();
  mem_if #(.LINE_BYTES(4)) bus1 ();
  mem_if #(.LINE_BYTES(4)) bmem ();

  mem_bus_arbiter #(.LINE_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (bus0),
    .m1    (bus1),
    .mem   (bmem)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural view: who holds the bus (-1 none), who won last, who is owed a done.
  int mdl_owner   = -1;
  int mdl_last    = 1;
  int mdl_done_to = -1;
  int exp_sel     = -1;
  int hit_seen    = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_m(input int m, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] e);
    if (m == 0) begin
      bus0.read_en = rd; bus0.write_en = wr; bus0.addr = a; bus0.data_i = d; bus0.data_en = e;
    end else begin
      bus1.read_en = rd; bus1.write_en = wr; bus1.addr = a; bus1.data_i = d; bus1.data_en = e;
    end
  endtask

  // Predict this cycle's outputs from the current inputs and compare.
  task automatic settle();
    logic r0, r1, erd, ewr;
    logic [31:0] ea, ed;
    logic [3:0]  ee;
    #1;
    r0 = bus0.read_en | bus0.write_en;
    r1 = bus1.read_en | bus1.write_en;
    exp_sel = -1;
    if (!reset) begin
      if (mdl_owner >= 0) begin
        if ((mdl_owner == 0) ? r0 : r1) exp_sel = mdl_owner;
      end else if (r0 && r1) exp_sel = 1 - mdl_last;
      else if (r0) exp_sel = 0;
      else if (r1) exp_sel = 1;
    end
    ea = '0; ed = '0; ee = '0; erd = 1'b0; ewr = 1'b0;
    if (exp_sel == 0) begin
      ea = bus0.addr; ed = bus0.data_i; ee = bus0.data_en; erd = bus0.read_en; ewr = bus0.write_en;
    end else if (exp_sel == 1) begin
      ea = bus1.addr; ed = bus1.data_i; ee = bus1.data_en; erd = bus1.read_en; ewr = bus1.write_en;
    end
    check("mem_addr", bmem.addr, ea);
    check("mem_data_i", bmem.data_i, ed);
    check("mem_data_en", bmem.data_en, ee);
    check("mem_read_en", bmem.read_en, erd);
    check("mem_write_en", bmem.write_en, ewr);
    check("m0_hit", bus0.hit, (exp_sel == 0) && bmem.hit);
    check("m1_hit", bus1.hit, (exp_sel == 1) && bmem.hit);
    check("m0_done", bus0.done, !reset && bmem.done && (mdl_done_to == 0));
    check("m1_done", bus1.done, !reset && bmem.done && (mdl_done_to == 1));
    check("m0_data_o", bus0.data_o, bmem.data_o);
    check("m1_data_o", bus1.data_o, bmem.data_o);
  endtask

  // Commit the model across the rising edge and move to the next falling edge.
  task automatic advance();
    hit_seen = (exp_sel >= 0 && bmem.hit) ? exp_sel : -1;
    if (reset) begin
      mdl_owner = -1; mdl_last = 1; mdl_done_to = -1;
    end else begin
      mdl_done_to = hit_seen;
      if (hit_seen >= 0) begin
        mdl_last  = hit_seen;
        mdl_owner = -1;
      end else begin
        mdl_owner = exp_sel;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    bmem.hit = 1'b0; bmem.done = 1'b0; bmem.data_o = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    settle(); advance();
    settle(); advance();
    reset = 1'b0;
  endtask

  initial begin
    bit mbusy[2];
    reset = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    // Reset state: idle port, nothing routed back.
    settle();
    check("rst_rd", bmem.read_en, 0);
    check("rst_wr", bmem.write_en, 0);
    check("rst_done0", bus0.done, 0);
    advance();

    // Single master read: hit at +2, done with data at +3.
    set_m(0, 1, 0, 32'h100, 0, 0);
    settle(); check("t1_addr", bmem.addr, 32'h100); advance();
    settle(); advance();
    bmem.hit = 1'b1;
    settle(); check("t1_hit0", bus0.hit, 1); check("t1_hit1", bus1.hit, 0); advance();
    set_m(0, 0, 0, 0, 0, 0);
    bmem.hit = 1'b0; bmem.done = 1'b1; bmem.data_o = 32'hDEADBEEF;
    settle();
    check("t1_done0", bus0.done, 1); check("t1_data", bus0.data_o, 32'hDEADBEEF);
    check("t1_done1", bus1.done, 0);
    advance();
    bmem.done = 1'b0;

    // Tie after reset: m0 first, then m1 with no bubble.
    do_reset();
    set_m(0, 1, 0, 32'h200, 0, 0);
    set_m(1, 1, 0, 32'h300, 0, 0);
    settle(); check("t2_first", bmem.addr, 32'h200); advance();
    bmem.hit = 1'b1;
    settle(); check("t2_hit0", bus0.hit, 1); advance();
    set_m(0, 0, 0, 0, 0, 0);
    bmem.hit = 1'b0; bmem.done = 1'b1;
    settle(); check("t2_second", bmem.addr, 32'h300); check("t2_done0", bus0.done, 1); advance();
    bmem.done = 1'b0; bmem.hit = 1'b1;
    settle(); check("t2_hit1", bus1.hit, 1); advance();
    set_m(1, 0, 0, 0, 0, 0);
    bmem.hit = 1'b0; bmem.done = 1'b1;
    settle(); check("t2_done1", bus1.done, 1); advance();
    bmem.done = 1'b0;

    // Round-robin fairness with single-cycle hits.
    set_m(0, 1, 0, 32'h200, 0, 0);
    set_m(1, 1, 0, 32'h300, 0, 0);
    bmem.hit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bmem.done = (i > 0);
      settle(); check("rr_addr", bmem.addr, (i % 2) ? 32'h300 : 32'h200); advance();
    end
    idle(); bmem.done = 1'b1;
    settle(); advance();
    bmem.done = 1'b0;

    // Abort: pointer to m0 first, then m1 aborts; next tie must go to m1.
    set_m(0, 1, 0, 32'h200, 0, 0); bmem.hit = 1'b1;
    settle(); check("t4_m0", bmem.addr, 32'h200); advance();
    idle(); bmem.done = 1'b1;
    settle(); advance();
    idle();
    set_m(1, 1, 0, 32'h300, 0, 0);
    settle(); check("t4_m1", bmem.addr, 32'h300); advance();
    set_m(1, 0, 0, 0, 0, 0);
    settle(); check("t4_abort_rd", bmem.read_en, 0); advance();
    bmem.done = 1'b1;
    settle(); check("t4_abort_done", bus1.done, 0); advance();
    bmem.done = 1'b0;
    set_m(0, 1, 0, 32'h200, 0, 0);
    set_m(1, 1, 0, 32'h300, 0, 0);
    bmem.hit = 1'b1;
    settle(); check("t4_tie", bmem.addr, 32'h300); advance();
    idle();
    settle(); advance();

    // Reset right after a write hit: the trailing done is suppressed.
    set_m(0, 0, 1, 32'h40, 32'h12345678, 4'hF); bmem.hit = 1'b1;
    settle();
    check("t5_wr", bmem.write_en, 1); check("t5_data", bmem.data_i, 32'h12345678);
    check("t5_hit", bus0.hit, 1);
    advance();
    reset = 1'b1; idle(); bmem.done = 1'b1;
    settle(); check("t5_done0", bus0.done, 0); advance();
    reset = 1'b0; bmem.done = 1'b0;
    settle(); check("t5_idle", bmem.write_en, 0); advance();
    set_m(0, 1, 0, 32'h200, 0, 0);
    set_m(1, 1, 0, 32'h300, 0, 0);
    settle(); check("t5_tie", bmem.addr, 32'h200); advance();
    idle();
    settle(); advance();

    // Spurious done with no preceding hit.
    bmem.done = 1'b1;
    settle(); check("t6_done0", bus0.done, 0); check("t6_done1", bus1.done, 0); advance();
    bmem.done = 1'b0;

    // Randomized traffic against the model.
    mbusy[0] = 1'b0; mbusy[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (hit_seen == m) mbusy[m] = 1'b0;
        if (mbusy[m] && ($urandom % 40 == 0)) begin
          mbusy[m] = 1'b0;
          set_m(m, 0, 0, 0, 0, 0);
        end
        if (!mbusy[m]) begin
          if ($urandom % 3 == 0) begin
            int op;
            op = $urandom_range(1, 3);
            mbusy[m] = 1'b1;
            set_m(m, op[0], op[1], $urandom, $urandom, 4'($urandom));
          end else begin
            set_m(m, 0, 0, 0, 0, 0);
          end
        end
      end
      bmem.hit    = ($urandom % 2 == 0);
      bmem.done   = (hit_seen >= 0) ? ($urandom % 8 != 0) : ($urandom % 10 == 0);
      bmem.data_o = $urandom;
      reset       = ($urandom % 100 == 0);
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
